// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch front end: reset vector, fetch FSM encodings
// and the NOP word used for an empty F/D register.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_WAIT = 2'd2;
  localparam fetch_state_t ST_FULL = 2'd3;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer that catches a fetch response arriving while
// the F/D register is stalled. Clear beats load, load beats pop.
module fetch_skid_buf
  import mips_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] instr_i,
  output logic         valid_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] instr_o
);

  logic         valid_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] instr_q;

  // NOTE: state registers use non-blocking (<=) assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by valid_q, so it carries no reset; only the
  // control bit needs a defined value out of reset.
  always_ff @(posedge clk) begin
    if (load_i && !clear_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and instruction-fetch sequencer for the 5-stage MIPS pipeline:
// single-outstanding imem handshake, F/D output register, skid buffer, delay-slot redirects.
module fetch_sequencer #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o
);

  import mips_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            kill_q, kill_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            skid_valid, skid_valid_nxt;
  logic            skid_load, skid_pop, skid_clear;
  logic [XLEN-1:0] skid_pc, skid_instr;

  logic            consume, redirect, grant, rsp_fire, rsp_keep;
  logic [1:0]      occ_next;

  assign consume  = out_valid_q & ~stall_i;
  // A redirect only counts on the edge that consumes its delay slot.
  assign redirect = redirect_i & consume;
  assign grant    = (state_q == ST_REQ) & imem_gnt_i;
  assign rsp_fire = (state_q == ST_WAIT) & imem_rvalid_i;
  assign rsp_keep = rsp_fire & ~kill_q & ~redirect;

  fetch_skid_buf #(
    .W (XLEN)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .clear_i (skid_clear),
    .pc_i    (rsp_pc_q),
    .instr_i (imem_rdata_i),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Response routing into the F/D register and skid, oldest entry first.
  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
    skid_clear  = 1'b0;
    if (redirect) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP;
      skid_clear  = 1'b1;
    end else if (!(out_valid_q && stall_i)) begin
      if (skid_valid) begin
        out_valid_d = 1'b1;
        out_instr_d = skid_instr;
        out_pc_d    = skid_pc;
        skid_pop    = 1'b1;
        skid_load   = rsp_keep;
      end else if (rsp_keep) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_rdata_i;
        out_pc_d    = rsp_pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rsp_keep) begin
      skid_load = 1'b1;
    end
  end

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (skid_clear) begin
      skid_valid_nxt = 1'b0;
    end else if (skid_load) begin
      skid_valid_nxt = 1'b1;
    end else if (skid_pop) begin
      skid_valid_nxt = 1'b0;
    end
    occ_next = {1'b0, out_valid_d} + {1'b0, skid_valid_nxt};
  end

  // Sequencing: a request is only issued when its response is sure to have a slot.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    kill_d   = kill_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (grant) begin
          state_d  = ST_WAIT;
          pc_d     = pc_q + XLEN'(4);
          rsp_pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (rsp_fire) begin
          kill_d  = 1'b0;
          state_d = (occ_next < 2'd2) ? ST_REQ : ST_FULL;
        end
      end
      ST_FULL: begin
        if (occ_next < 2'd2) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      kill_d  = grant | ((state_q == ST_WAIT) & ~imem_rvalid_i);
      state_d = kill_d ? ST_WAIT : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_req_o  = (state_q == ST_REQ);
  assign imem_addr_o = {pc_q[XLEN-1:2], 2'b00};
  assign if_valid_o  = out_valid_q;
  assign if_instr_o  = out_instr_q;
  assign if_pc_o     = out_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a simple instruction memory
// whose response timing is dictated cycle by cycle from the vector table.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  logic [31:0] pend_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Memory model: remembers the granted address, answers when the table says rvalid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr <= 32'h0000_3000;
    end else if (imem_req_o && imem_gnt_i) begin
      pend_addr <= imem_addr_o;
    end
  end
  assign imem_rdata_i = imem_rvalid_i ? instr_of(pend_addr) : 32'h0;

  always @(posedge clk) begin
    if (rst_n && redirect_i) begin
      assert (!stall_i && if_valid_o)
        else $error("redirect precondition violated at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        gnt;
    logic        rv;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stall, input logic gnt, input logic rv,
                     input logic redir, input logic [31:0] rpc, input logic req,
                     input logic [31:0] addr, input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.gnt = gnt; v.rv = rv; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    // rst, stall, gnt, rv, redir, rpc  |  req, addr, valid, pc
    add(0, 0, 0, 0, 0, 0,            0, 32'h3000, 0, 0);
    add(1, 0, 0, 0, 0, 0,            0, 32'h3000, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3000, 0, 0);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3004, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3004, 1, 32'h3000);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3008, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3008, 1, 32'h3004);
    add(1, 0, 0, 1, 0, 0,            0, 32'h300C, 0, 0);
    // four-cycle stall: 0x300C lands in the skid, requests stop
    add(1, 1, 1, 0, 0, 0,            1, 32'h300C, 1, 32'h3008);
    add(1, 1, 0, 1, 0, 0,            0, 32'h3010, 1, 32'h3008);
    add(1, 1, 1, 0, 0, 0,            0, 32'h3010, 1, 32'h3008);
    add(1, 1, 1, 0, 0, 0,            0, 32'h3010, 1, 32'h3008);
    add(1, 0, 1, 0, 0, 0,            0, 32'h3010, 1, 32'h3008);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3010, 1, 32'h300C);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3014, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3014, 1, 32'h3010);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3018, 0, 0);
    // fresh start, then branch at 0x3008 with delay slot 0x300C, target 0x3100
    add(0, 0, 0, 0, 0, 0,            0, 32'h3000, 0, 0);
    add(1, 0, 0, 0, 0, 0,            0, 32'h3000, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3000, 0, 0);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3004, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3004, 1, 32'h3000);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3008, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3008, 1, 32'h3004);
    add(1, 0, 0, 1, 0, 0,            0, 32'h300C, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h300C, 1, 32'h3008);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3010, 0, 0);
    add(1, 1, 1, 0, 0, 0,            1, 32'h3010, 1, 32'h300C);
    add(1, 0, 0, 0, 1, 32'h3100,     0, 32'h3014, 1, 32'h300C);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3100, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3100, 0, 0);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3104, 0, 0);
    // jr redirect on the same edge as a grant: fetch of 0x3104 is killed
    add(1, 0, 1, 0, 1, 32'h3200,     1, 32'h3104, 1, 32'h3100);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3200, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3200, 0, 0);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3204, 0, 0);
    // grant withheld five cycles: request held, output drains
    add(1, 1, 0, 0, 0, 0,            1, 32'h3204, 1, 32'h3200);
    add(1, 0, 0, 0, 0, 0,            1, 32'h3204, 1, 32'h3200);
    add(1, 0, 0, 0, 0, 0,            1, 32'h3204, 0, 0);
    add(1, 0, 0, 0, 0, 0,            1, 32'h3204, 0, 0);
    add(1, 0, 0, 0, 0, 0,            1, 32'h3204, 0, 0);
    add(1, 0, 1, 0, 0, 0,            1, 32'h3204, 0, 0);
    add(1, 0, 0, 1, 0, 0,            0, 32'h3208, 0, 0);
    // unaligned target has its low bits dropped; PC wraps past the top
    add(1, 0, 0, 0, 1, 32'hFFFF_FFFE, 1, 32'h3208, 1, 32'h3204);
    add(1, 0, 1, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0);
    add(1, 0, 0, 1, 0, 0,            0, 32'h0000_0000, 0, 0);
    add(1, 1, 0, 0, 0, 0,            1, 32'h0000_0000, 1, 32'hFFFF_FFFC);

    #1 rst_n = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n         = vecs[i].rst;
      stall_i       = vecs[i].stall;
      imem_gnt_i    = vecs[i].gnt;
      imem_rvalid_i = vecs[i].rv;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      #1;
      check($sformatf("v%0d req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].req});
      check($sformatf("v%0d addr", i), imem_addr_o, vecs[i].addr);
      check($sformatf("v%0d valid", i), {31'b0, if_valid_o}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) begin
        check($sformatf("v%0d pc", i), if_pc_o, vecs[i].pc);
        check($sformatf("v%0d instr", i), if_instr_o, instr_of(vecs[i].pc));
      end else if (!vecs[i].rst) begin
        check($sformatf("v%0d rst pc", i), if_pc_o, 32'h0);
        check($sformatf("v%0d rst instr", i), if_instr_o, 32'h0);
      end
    end

    // Reset asserted mid-cycle while a request is outstanding.
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i    = 1'b1;
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    #1;
    check("wait req", {31'b0, imem_req_o}, 32'h0);
    check("wait addr", imem_addr_o, 32'h0000_0004);
    check("wait held pc", if_pc_o, 32'hFFFF_FFFC);
    #2 rst_n = 1'b0;
    #1;
    check("async req", {31'b0, imem_req_o}, 32'h0);
    check("async addr", imem_addr_o, 32'h3000);
    check("async valid", {31'b0, if_valid_o}, 32'h0);
    check("async pc", if_pc_o, 32'h0);
    check("async instr", if_instr_o, 32'h0);

    @(negedge clk);
    rst_n   = 1'b1;
    stall_i = 1'b0;
    #1;
    check("restart idle req", {31'b0, imem_req_o}, 32'h0);
    @(negedge clk);
    imem_gnt_i = 1'b1;
    #1;
    check("restart req", {31'b0, imem_req_o}, 32'h1);
    check("restart addr", imem_addr_o, 32'h3000);
    @(negedge clk);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    #1;
    check("restart wait addr", imem_addr_o, 32'h3004);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    #1;
    check("restart valid", {31'b0, if_valid_o}, 32'h1);
    check("restart pc", if_pc_o, 32'h3000);
    check("restart instr", if_instr_o, instr_of(32'h3000));
    check("restart next addr", imem_addr_o, 32'h3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
